mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Two-port sequencer and arbiter for the shared external byte-wide memory bus: one 32Kx8 EEPROM (ROM region) and one 512Kx8 SRAM (RAM region).
- Accepts byte read/write requests from the CPU core (port 0) and the loader/DMA (port 1), grants round-robin, and decodes the chip select.
- Generates nCE/nOE/nWE strobes with programmable setup/pulse/hold cycle counts, and returns read data with a one-cycle valid pulse.

Parameters:
- SETUP_CYC, 1: cycles the address and chip select are stable before the nOE/nWE strobe (range 1-15).
- RD_CYC, 2: cycles nOE is held low; read data is sampled on the last of them (range 1-15).
- WR_CYC, 2: cycles nWE is held low (range 1-15).
- HOLD_CYC, 1: cycles address, data and chip select are held after the strobe rises (range 1-15).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  request pending (0 = CPU, 1 = loader).
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  20  byte address; bit19 = 0 selects ROM (bits 14:0 used), bit19 = 1 selects RAM (bits 18:0 used).
- req0_wdata / req1_wdata  in  8  write data.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready).
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse: read data valid, or write complete.
- rsp_rdata  out  8  read data; meaningful only while an rspN_valid is high.
- mem_a  out  19  memory address bus.
- mem_d_out  out  8  data driven toward memory.
- mem_d_oe  out  1  enables the top-level tristate driver for mem_d_out.
- mem_d_in  in  8  data bus as seen by the controller.
- rom_nce / ram_nce  out  1  chip selects, active-low.
- mem_noe / mem_nwe  out  1  output enable / write enable, active-low.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: rom_nce, ram_nce, mem_noe, mem_nwe = 1; mem_d_oe = 0; mem_a, mem_d_out, rsp_rdata = 0; all ready, rsp_valid and busy = 0; round-robin pointer = port 0; state = IDLE.
- Reset mid-cycle: all strobes deassert immediately (asynchronous); the in-flight request is dropped with no response.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE. A single down-counter loads SETUP_CYC, RD_CYC/WR_CYC, or HOLD_CYC on state entry.
- IDLE arbitration:
  - Exactly one valid port: that port is granted.
  - Both valid: grant the port not served last (round-robin pointer).
  - readyN is asserted combinationally in IDLE for the granted port only.
  - On acceptance, latch addr, write and wdata, set the pointer to the granted port, then move to SETUP.
- SETUP:
  - mem_a driven; the decoded nCE is low (exactly one of rom_nce/ram_nce); mem_noe = mem_nwe = 1.
  - On a write, mem_d_oe = 1 with mem_d_out = wdata.
- STROBE:
  - Read: mem_noe = 0 for RD_CYC cycles; mem_d_in is captured into rsp_rdata on the final cycle.
  - Write: mem_nwe = 0 for WR_CYC cycles; mem_d_oe stays 1.
  - mem_noe and mem_nwe are never low together.
- HOLD: both strobes high; address, chip select and (on writes) mem_d_oe held for HOLD_CYC cycles.
- RESP:
  - nCE = 1 and mem_d_oe = 0.
  - rspN_valid = 1 for the granted port for exactly one cycle, then IDLE.
- Minimum transaction time: 1 (IDLE accept) + SETUP + STROBE + HOLD + 1 (RESP) cycles; 6 cycles at defaults. Back-to-back accept is allowed in the cycle after RESP.
- mem_d_oe and mem_noe are never active together, including across state boundaries.
- A requester may drop valid while not granted; behaviour is then unaffected. Once granted, the request is committed.
- Port 1 may write ROM (for EEPROM programming); port 0 writes to ROM follow the optional feature below.

Optional Feature:
- Macro: MEMCTL_ROM_WP_EN.
- Defined: a write from port 0 to the ROM region skips SETUP/STROBE/HOLD and asserts no strobe. It goes straight to RESP, pulsing rsp0_valid together with an extra output wp_err = 1 (the port exists only when the macro is defined).
- Undefined: ROM writes from either port run the normal write cycle.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RESP);
  - region decode constants (ROM_SEL_BIT = 19, ROM_ADDR_W = 15, RAM_ADDR_W = 19);
  - default timing constants.
- One natural sub-module, mem_rr_arb2: the 2-way round-robin arbiter with a last-grant pointer.

Test Plan:
- Port 0 reads addr 0x00123 (ROM returns 0xA5), defaults -> rom_nce low 4 cycles, mem_noe low 2 cycles, rsp0_valid after 6 cycles with rsp_rdata = 0xA5; ram_nce stays 1.
- Port 1 writes 0x3C to 0x80010 -> ram_nce low, mem_a = 0x00010, mem_nwe low 2 cycles, mem_d_oe high from SETUP through HOLD, and the RAM model holds 0x3C.
- Both ports valid continuously for 4 transactions -> grants alternate 0,1,0,1 with no gap beyond one cycle between RESP and the next accept.
- rst asserted mid-STROBE of a write -> mem_nwe, nCE and mem_d_oe return to inactive in the same cycle, no rsp pulse, and the next request after reset runs normally.
- Run with SETUP_CYC = 3, RD_CYC = 4, HOLD_CYC = 2 -> read takes 11 cycles and data is sampled on the 4th nOE-low cycle.
- With MEMCTL_ROM_WP_EN, port 0 writes 0x00005 -> no nWE pulse, rsp0_valid and wp_err pulse 2 cycles after accept; port 1 writing the same address performs a normal write.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, region decode and default
// strobe timing for the external EEPROM/SRAM bus controller.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_e;

  localparam int ROM_SEL_BIT = 19;
  localparam int ROM_ADDR_W  = 15;
  localparam int RAM_ADDR_W  = 19;
  localparam int CNT_W       = 4;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_RD_CYC    = 2;
  localparam int DEF_WR_CYC    = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic logic [RAM_ADDR_W-1:0] bus_addr(
    input logic [19:0] a
  );
    if (a[ROM_SEL_BIT]) return a[RAM_ADDR_W-1:0];
    return {{(RAM_ADDR_W-ROM_ADDR_W){1'b0}},
            a[ROM_ADDR_W-1:0]};
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_arb.sv
// mem_rr_arb2: two-way round-robin arbiter; the pointer holds the
// port granted last, so a contended grant goes to the other one.
module mem_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic accept_i,
  output logic gnt_valid_o,
  output logic gnt_o
);

  logic last_q;

  // Grant the sole requester, or the port not served last.
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    if (req0_i && req1_i) gnt_o = ~last_q;
    else                  gnt_o = req1_i;
  end

  // Remember the port served by the accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         last_q <= 1'b0;
    else if (accept_i) last_q <= gnt_o;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: two-port sequencer for the shared EEPROM/SRAM bus.
// Optional MEMCTL_ROM_WP_EN: port 0 ROM writes are refused (wp_err).
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int RD_CYC    = DEF_RD_CYC,
  parameter int WR_CYC    = DEF_WR_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [19:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [19:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [7:0]  rsp_rdata,
  output logic [18:0] mem_a,
  output logic [7:0]  mem_d_out,
  output logic        mem_d_oe,
  input  logic [7:0]  mem_d_in,
  output logic        rom_nce,
  output logic        ram_nce,
  output logic        mem_noe,
  output logic        mem_nwe,
`ifdef MEMCTL_ROM_WP_EN
  output logic        wp_err,
`endif
  output logic        busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               port_q, wr_q, rom_q;
  logic [18:0]        a_q;
  logic [7:0]         wd_q, rd_q;
  logic               gnt_valid, gnt, accept;
  logic               wp_hit, last_cyc;
  logic [19:0]        sel_addr;
  logic               sel_wr;
  logic [7:0]         sel_wd;

  mem_rr_arb2 u_arb (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0_valid),
    .req1_i      (req1_valid),
    .accept_i    (accept),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  assign accept   = (state_q == IDLE) && gnt_valid;
  assign sel_addr = gnt ? req1_addr  : req0_addr;
  assign sel_wr   = gnt ? req1_write : req0_write;
  assign sel_wd   = gnt ? req1_wdata : req0_wdata;
  assign last_cyc = (cnt_q == CNT_W'(1));

`ifdef MEMCTL_ROM_WP_EN
  logic wp_q;
  assign wp_hit = !gnt && sel_wr && !sel_addr[ROM_SEL_BIT];
  assign wp_err = (state_q == RESP) && wp_q;

  // Flag a refused ROM write so RESP can report it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wp_q <= 1'b0;
    else if (accept) wp_q <= wp_hit;
  end
`else
  assign wp_hit = 1'b0;
`endif

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase sequencing; the counter reloads on each phase entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (wp_hit) begin
            state_d = RESP;
          end else begin
            state_d = SETUP;
            cnt_d   = CNT_W'(SETUP_CYC);
          end
        end
      end
      SETUP: begin
        if (last_cyc) begin
          state_d = STROBE;
          cnt_d   = wr_q ? CNT_W'(WR_CYC)
                         : CNT_W'(RD_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (last_cyc) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (last_cyc) state_d = RESP;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request; capture read data on the last nOE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q <= 1'b0;
      wr_q   <= 1'b0;
      rom_q  <= 1'b0;
      a_q    <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      if (accept) begin
        port_q <= gnt;
        wr_q   <= sel_wr;
        rom_q  <= !sel_addr[ROM_SEL_BIT];
        a_q    <= bus_addr(sel_addr);
        wd_q   <= sel_wd;
      end
      if (state_q == STROBE && !wr_q && last_cyc)
        rd_q <= mem_d_in;
    end
  end

  // Strobes, handshakes and responses decoded from the phase.
  always_comb begin
    rom_nce    = 1'b1;
    ram_nce    = 1'b1;
    mem_noe    = 1'b1;
    mem_nwe    = 1'b1;
    mem_d_oe   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt_valid && !gnt;
        req1_ready = gnt_valid && gnt;
      end
      SETUP, HOLD: begin
        rom_nce  = !rom_q;
        ram_nce  = rom_q;
        mem_d_oe = wr_q;
      end
      STROBE: begin
        rom_nce  = !rom_q;
        ram_nce  = rom_q;
        mem_d_oe = wr_q;
        mem_noe  = wr_q;
        mem_nwe  = !wr_q;
      end
      RESP: begin
        rsp0_valid = !port_q;
        rsp1_valid = port_q;
      end
      default: ;
    endcase
  end

  assign mem_a     = a_q;
  assign mem_d_out = wd_q;
  assign rsp_rdata = rd_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized self-checking bench for mem_bus_ctrl
// with a behavioural memory and a rule-based expectation model.
module tb_mem_bus_ctrl;

  typedef struct {
    int          lat;
    int          rom_lo;
    int          ram_lo;
    int          noe_lo;
    int          nwe_lo;
    int          doe_lo;
    logic [7:0]  rd;
    logic [18:0] a;
    logic [1:0]  rsp;
    logic        wp;
    bit          tmo;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        r0v, r0w, r1v, r1w;
  logic [19:0] r0a, r1a;
  logic [7:0]  r0d, r1d;
  logic        q0r, q1r, s0v, s1v;
  logic [7:0]  rdata, mdo, mdi;
  logic [18:0] ma;
  logic        mdoe, romn, ramn, noe, nwe, busy;

  logic        b_r0v, b_r0w, b_r1v, b_r1w;
  logic [19:0] b_r0a, b_r1a;
  logic [7:0]  b_r0d, b_r1d;
  logic        b_q0r, b_q1r, b_s0v, b_s1v;
  logic [7:0]  b_rdata, b_mdo, b_mdi;
  logic [18:0] b_ma;
  logic        b_mdoe, b_romn, b_ramn, b_noe, b_nwe, b_busy;

`ifdef MEMCTL_ROM_WP_EN
  logic wp_a, wp_b;
`else
  logic wp_a;
  assign wp_a = 1'b0;
`endif

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_write(r0w),
    .req0_addr(r0a), .req0_wdata(r0d),
    .req1_valid(r1v), .req1_write(r1w),
    .req1_addr(r1a), .req1_wdata(r1d),
    .req0_ready(q0r), .req1_ready(q1r),
    .rsp0_valid(s0v), .rsp1_valid(s1v),
    .rsp_rdata(rdata), .mem_a(ma),
    .mem_d_out(mdo), .mem_d_oe(mdoe),
    .mem_d_in(mdi), .rom_nce(romn),
    .ram_nce(ramn), .mem_noe(noe),
    .mem_nwe(nwe),
`ifdef MEMCTL_ROM_WP_EN
    .wp_err(wp_a),
`endif
    .busy(busy)
  );

  mem_bus_ctrl #(
    .SETUP_CYC(3), .RD_CYC(4),
    .WR_CYC(2), .HOLD_CYC(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_write(b_r0w),
    .req0_addr(b_r0a), .req0_wdata(b_r0d),
    .req1_valid(b_r1v), .req1_write(b_r1w),
    .req1_addr(b_r1a), .req1_wdata(b_r1d),
    .req0_ready(b_q0r), .req1_ready(b_q1r),
    .rsp0_valid(b_s0v), .rsp1_valid(b_s1v),
    .rsp_rdata(b_rdata), .mem_a(b_ma),
    .mem_d_out(b_mdo), .mem_d_oe(b_mdoe),
    .mem_d_in(b_mdi), .rom_nce(b_romn),
    .ram_nce(b_ramn), .mem_noe(b_noe),
    .mem_nwe(b_nwe),
`ifdef MEMCTL_ROM_WP_EN
    .wp_err(wp_b),
`endif
    .busy(b_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int viol = 0;
  logic rr_last = 1'b0;
  logic [7:0] model_w [logic [19:0]];

  function automatic logic [7:0] fill(input logic [19:0] k);
    return k[7:0] ^ k[15:8] ^ (k[19] ? 8'h3C : 8'h5A);
  endfunction

  function automatic logic [19:0] canon(input logic [19:0] a);
    if (a[19]) return a;
    return {5'b0, a[14:0]};
  endfunction

  function automatic logic [7:0] model_rd(input logic [19:0] a);
    logic [19:0] k;
    k = canon(a);
    if (model_w.exists(k)) return model_w[k];
    return fill(k);
  endfunction

  // Behavioural EEPROM/SRAM: filled once, written while nWE is low.
  logic [7:0] rom_mem [0:32767];
  logic [7:0] ram_mem [0:65535];
  logic mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++)
        rom_mem[i] <= fill({5'b0, 15'(i)});
      for (int i = 0; i < 65536; i++)
        ram_mem[i] <= fill({4'b1000, 16'(i)});
      rom_mem[15'h0123] <= 8'hA5;
      mem_init <= 1'b1;
    end else if (!nwe && !ramn) begin
      ram_mem[ma[15:0]] <= mdo;
    end else if (!nwe && !romn) begin
      rom_mem[ma[14:0]] <= mdo;
    end
  end

  always_comb begin
    mdi = 8'hEE;
    if (!noe && !romn)      mdi = rom_mem[ma[14:0]];
    else if (!noe && !ramn) mdi = ram_mem[ma[15:0]];
  end

  // Slow instance sees C0 + index of the current nOE-low cycle.
  logic [3:0] b_cnt = 4'd0;
  always @(posedge clk) begin
    if (b_noe) b_cnt <= 4'd0;
    else       b_cnt <= b_cnt + 4'd1;
  end
  assign b_mdi = 8'hC0 | {4'b0, b_cnt};

  // Bus protocol watch on the default instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (!romn && !ramn) viol <= viol + 1;
      if (!noe && !nwe)   viol <= viol + 1;
      if (mdoe && !noe)   viol <= viol + 1;
    end
  end

  task automatic do_txn(
    input  logic        port,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [7:0]  wd,
    output obs_t        o
  );
    int guard;
    o = '{default: 0};
    @(negedge clk);
    if (port) begin
      r1v = 1'b1; r1w = wr; r1a = addr; r1d = wd;
    end else begin
      r0v = 1'b1; r0w = wr; r0a = addr; r0d = wd;
    end
    #1;
    guard = 0;
    while (!(port ? q1r : q0r) && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 20) begin
      o.tmo = 1'b1; r0v = 1'b0; r1v = 1'b0;
      return;
    end
    o.lat = 1;
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    #1;
    guard = 0;
    while (guard < 100) begin
      o.lat++;
      if (!romn) o.rom_lo++;
      if (!ramn) o.ram_lo++;
      if (!noe)  o.noe_lo++;
      if (!nwe)  o.nwe_lo++;
      if (mdoe)  o.doe_lo++;
      if (!romn || !ramn) o.a = ma;
      if (s0v || s1v) begin
        o.rsp = {s1v, s0v};
        o.rd  = rdata;
        o.wp  = wp_a;
        break;
      end
      @(negedge clk); #1; guard++;
    end
    if (guard >= 100) o.tmo = 1'b1;
    rr_last = port;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({romn, ramn, noe, nwe} !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_strobes got %b want 1111",
               {romn, ramn, noe, nwe});
    end
    vectors++;
    if ({mdoe, q0r, q1r, s0v, s1v, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 000000",
               {mdoe, q0r, q1r, s0v, s1v, busy});
    end
    vectors++;
    if ({ma, mdo, rdata} !== 35'b0) begin
      miscompares++;
      $display("FAIL reset_buses got %h want 0",
               {ma, mdo, rdata});
    end
    vectors++;
    if ({b_busy, b_noe, b_romn} !== 3'b011) begin
      miscompares++;
      $display("FAIL reset_slow got %b want 011",
               {b_busy, b_noe, b_romn});
    end
    @(negedge clk);
    rst = 1'b0;
    rr_last = 1'b0;
  endtask

  task automatic test_rom_read();
    obs_t o;
    do_txn(1'b0, 1'b0, 20'h00123, 8'h00, o);
    vectors++;
    if (o.tmo) begin
      miscompares++; $display("FAIL rom_rd_timeout");
    end
    vectors++;
    if (o.lat !== 6) begin
      miscompares++;
      $display("FAIL rom_rd_lat got %0d want 6", o.lat);
    end
    vectors++;
    if (o.rom_lo !== 4 || o.ram_lo !== 0) begin
      miscompares++;
      $display("FAIL rom_rd_nce got rom %0d ram %0d want 4 0",
               o.rom_lo, o.ram_lo);
    end
    vectors++;
    if (o.noe_lo !== 2 || o.nwe_lo !== 0 || o.doe_lo !== 0) begin
      miscompares++;
      $display("FAIL rom_rd_strb got %0d %0d %0d want 2 0 0",
               o.noe_lo, o.nwe_lo, o.doe_lo);
    end
    vectors++;
    if (o.rd !== 8'hA5 || o.rsp !== 2'b01) begin
      miscompares++;
      $display("FAIL rom_rd_data got %h/%b want a5/01",
               o.rd, o.rsp);
    end
  endtask

  task automatic test_ram_write();
    obs_t o;
    do_txn(1'b1, 1'b1, 20'h80010, 8'h3C, o);
    model_w[20'h80010] = 8'h3C;
    vectors++;
    if (o.tmo || o.lat !== 6) begin
      miscompares++;
      $display("FAIL ram_wr_lat got %0d want 6", o.lat);
    end
    vectors++;
    if (o.ram_lo !== 4 || o.rom_lo !== 0 || o.a !== 19'h00010) begin
      miscompares++;
      $display("FAIL ram_wr_sel got %0d %0d a=%h want 4 0 00010",
               o.ram_lo, o.rom_lo, o.a);
    end
    vectors++;
    if (o.nwe_lo !== 2 || o.doe_lo !== 4 || o.noe_lo !== 0) begin
      miscompares++;
      $display("FAIL ram_wr_strb got %0d %0d %0d want 2 4 0",
               o.nwe_lo, o.doe_lo, o.noe_lo);
    end
    vectors++;
    if (ram_mem[16'h0010] !== 8'h3C || o.rsp !== 2'b10) begin
      miscompares++;
      $display("FAIL ram_wr_mem got %h/%b want 3c/10",
               ram_mem[16'h0010], o.rsp);
    end
  endtask

  task automatic test_rom_write();
    obs_t o;
    logic [7:0] d0, d1;
    int lat_exp, nwe_exp;
    logic wp_exp;
    logic [7:0] mem_exp;
    d0 = 8'($urandom);
    d1 = ~d0;
`ifdef MEMCTL_ROM_WP_EN
    wp_exp = 1'b1; lat_exp = 2; nwe_exp = 0;
    mem_exp = model_rd(20'h00005);
`else
    wp_exp = 1'b0; lat_exp = 6; nwe_exp = 2;
    mem_exp = d0;
    model_w[20'h00005] = d0;
`endif
    do_txn(1'b0, 1'b1, 20'h00005, d0, o);
    vectors++;
    if (o.tmo || o.lat !== lat_exp || o.wp !== wp_exp) begin
      miscompares++;
      $display("FAIL rom_wr_p0 got lat %0d wp %b want %0d %b",
               o.lat, o.wp, lat_exp, wp_exp);
    end
    vectors++;
    if (o.nwe_lo !== nwe_exp || o.rsp !== 2'b01) begin
      miscompares++;
      $display("FAIL rom_wr_p0_strb got %0d/%b want %0d/01",
               o.nwe_lo, o.rsp, nwe_exp);
    end
    vectors++;
    if (rom_mem[15'h0005] !== mem_exp) begin
      miscompares++;
      $display("FAIL rom_wr_p0_mem got %h want %h",
               rom_mem[15'h0005], mem_exp);
    end
    do_txn(1'b1, 1'b1, 20'h00005, d1, o);
    model_w[20'h00005] = d1;
    vectors++;
    if (o.tmo || o.lat !== 6 || o.nwe_lo !== 2 || o.wp !== 1'b0) begin
      miscompares++;
      $display("FAIL rom_wr_p1 got lat %0d nwe %0d wp %b want 6 2 0",
               o.lat, o.nwe_lo, o.wp);
    end
    vectors++;
    if (rom_mem[15'h0005] !== d1) begin
      miscompares++;
      $display("FAIL rom_wr_p1_mem got %h want %h",
               rom_mem[15'h0005], d1);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] a0, a1;
    int acc_cyc[$];
    logic acc_port[$];
    logic rsp_port[$];
    logic [7:0] rsp_d[$];
    int cyc;
    logic exp_p;
    a0 = {9'h000, 7'($urandom), 4'h0};
    a1 = {4'h8, 12'($urandom), 4'h0};
    cyc = 0;
    @(negedge clk);
    r0v = 1'b1; r0w = 1'b0; r0a = a0;
    r1v = 1'b1; r1w = 1'b0; r1a = a1;
    #1;
    while (acc_cyc.size() < 4 && cyc < 60) begin
      if (q0r || q1r) begin
        acc_cyc.push_back(cyc);
        acc_port.push_back(q1r);
      end
      if (s0v || s1v) begin
        rsp_port.push_back(s1v);
        rsp_d.push_back(rdata);
      end
      @(negedge clk); #1; cyc++;
    end
    r0v = 1'b0; r1v = 1'b0;
    while (rsp_port.size() < 4 && cyc < 100) begin
      if (s0v || s1v) begin
        rsp_port.push_back(s1v);
        rsp_d.push_back(rdata);
      end
      @(negedge clk); #1; cyc++;
    end
    vectors++;
    if (acc_cyc.size() != 4 || rsp_port.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_count got %0d acc %0d rsp want 4 4",
               acc_cyc.size(), rsp_port.size());
      return;
    end
    exp_p = ~rr_last;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (acc_port[i] !== exp_p) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d] got %b want %b",
                 i, acc_port[i], exp_p);
      end
      if (i > 0) begin
        vectors++;
        if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
          miscompares++;
          $display("FAIL b2b_gap[%0d] got %0d want 6",
                   i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
      vectors++;
      if (rsp_port[i] !== exp_p ||
          rsp_d[i] !== model_rd(exp_p ? a1 : a0)) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d] got %b/%h want %b/%h", i,
                 rsp_port[i], rsp_d[i], exp_p,
                 model_rd(exp_p ? a1 : a0));
      end
      rr_last = exp_p;
      exp_p = ~exp_p;
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic port, wr, rom, wp;
    logic [19:0] addr;
    logic [18:0] a_exp;
    logic [7:0] wd;
    for (int i = 0; i < 40; i++) begin
      port = 1'($urandom);
      wr   = 1'($urandom);
      rom  = 1'($urandom);
      wd   = 8'($urandom);
      if (rom)
        addr = {1'b0, 4'($urandom), 11'h0, 4'($urandom)};
      else
        addr = {4'h8, 1'($urandom), 11'h0, 4'($urandom)};
      a_exp = rom ? {4'h0, addr[14:0]} : addr[18:0];
`ifdef MEMCTL_ROM_WP_EN
      wp = !port && wr && rom;
`else
      wp = 1'b0;
`endif
      do_txn(port, wr, addr, wd, o);
      vectors++;
      if (o.tmo || o.lat !== (wp ? 2 : 6) || o.wp !== wp ||
          o.rsp !== (port ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL rnd[%0d] lat %0d wp %b rsp %b want %0d %b p%0d",
                 i, o.lat, o.wp, o.rsp, wp ? 2 : 6, wp, port);
      end
      if (!wp) begin
        vectors++;
        if (o.rom_lo !== (rom ? 4 : 0) ||
            o.ram_lo !== (rom ? 0 : 4) || o.a !== a_exp) begin
          miscompares++;
          $display("FAIL rnd_sel[%0d] got %0d %0d a=%h want a=%h",
                   i, o.rom_lo, o.ram_lo, o.a, a_exp);
        end
        vectors++;
        if (o.noe_lo !== (wr ? 0 : 2) || o.nwe_lo !== (wr ? 2 : 0) ||
            o.doe_lo !== (wr ? 4 : 0)) begin
          miscompares++;
          $display("FAIL rnd_strb[%0d] got %0d %0d %0d wr=%b",
                   i, o.noe_lo, o.nwe_lo, o.doe_lo, wr);
        end
      end
      if (!wr) begin
        vectors++;
        if (o.rd !== model_rd(addr)) begin
          miscompares++;
          $display("FAIL rnd_rd[%0d] addr %h got %h want %h",
                   i, addr, o.rd, model_rd(addr));
        end
      end
      if (wr && !wp) model_w[canon(addr)] = wd;
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    int guard;
    logic seen;
    @(negedge clk);
    r1v = 1'b1; r1w = 1'b1; r1a = 20'h80033; r1d = 8'h77;
    #1;
    guard = 0;
    while (!q1r && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    @(negedge clk);
    r1v = 1'b0;
    #1;
    while (nwe && guard < 40) begin
      @(negedge clk); #1; guard++;
    end
    vectors++;
    if (guard >= 40 || nwe !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_nostrobe got nwe %b want 0", nwe);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({nwe, ramn, romn, mdoe, busy} !== 5'b11100) begin
      miscompares++;
      $display("FAIL rst_mid_async got %b want 11100",
               {nwe, ramn, romn, mdoe, busy});
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      if (s0v || s1v) seen = 1'b1;
    end
    rst = 1'b0;
    rr_last = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (s0v || s1v) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid_rsp got pulse %b rdata %h want 0 00",
               seen, rdata);
    end
    do_txn(1'b0, 1'b0, 20'h80034, 8'h00, o);
    vectors++;
    if (o.tmo || o.lat !== 6 || o.rd !== model_rd(20'h80034)) begin
      miscompares++;
      $display("FAIL rst_mid_after got lat %0d rd %h want 6 %h",
               o.lat, o.rd, model_rd(20'h80034));
    end
  endtask

  task automatic test_slow_timing();
    int lat, noe_lo, guard;
    @(negedge clk);
    b_r0v = 1'b1; b_r0w = 1'b0; b_r0a = 20'h80100;
    #1;
    guard = 0;
    while (!b_q0r && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    lat = 1;
    noe_lo = 0;
    @(negedge clk);
    b_r0v = 1'b0;
    #1;
    while (guard < 100) begin
      lat++;
      if (!b_noe) noe_lo++;
      if (b_s0v) break;
      @(negedge clk); #1; guard++;
    end
    vectors++;
    if (guard >= 100 || lat !== 11) begin
      miscompares++;
      $display("FAIL slow_lat got %0d want 11", lat);
    end
    vectors++;
    if (noe_lo !== 4 || b_rdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL slow_sample got noe %0d data %h want 4 c3",
               noe_lo, b_rdata);
    end
  endtask

  task automatic test_protocol();
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL bus_protocol got %0d overlaps want 0", viol);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    r0v = 0; r0w = 0; r0a = '0; r0d = '0;
    r1v = 0; r1w = 0; r1a = '0; r1d = '0;
    b_r0v = 0; b_r0w = 0; b_r0a = '0; b_r0d = '0;
    b_r1v = 0; b_r1w = 0; b_r1a = '0; b_r1d = '0;
    model_w[20'h00123] = 8'hA5;
    test_reset();
    test_rom_read();
    test_ram_write();
    test_rom_write();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    test_slow_timing();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
